// File: rtl/spi_master_sequencer.sv
// Single-chip-select SPI master transfer sequencer (one DATA_W word per start, CPOL/CPHA selectable).
// Optional feature: SPI_LSB_FIRST_EN adds i_lsb_first to select LSB-first bit order.
module spi_master_sequencer #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              prescale_clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_cpol,
    input  logic              i_cpha,
`ifdef SPI_LSB_FIRST_EN
    input  logic              i_lsb_first,
`endif
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_miso,
    output logic              o_sclk,
    output logic              o_mosi,
    output logic              o_cs_n,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rx_data
);

    localparam int unsigned EW = $clog2(2 * DATA_W);
    localparam int unsigned IW = $clog2(DATA_W);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SETUP    = 3'd1;
    localparam logic [2:0] TRANSFER = 3'd2;
    localparam logic [2:0] HOLD     = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    logic [2:0]        r_state, w_state_nxt;
    logic [EW-1:0]     r_edge, w_edge_nxt;
    logic              r_cpol, w_cpol_nxt;
    logic              r_cpha, w_cpha_nxt;
    logic              r_lsb, w_lsb_nxt;
    logic [DATA_W-1:0] r_tx, w_tx_nxt;
    logic [DATA_W-1:0] r_rx_sh, w_rx_sh_nxt;
    logic              r_sclk, w_sclk_nxt;
    logic              r_mosi, w_mosi_nxt;
    logic              r_cs_n, w_cs_n_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;

    logic              w_lsb_in;
    logic              w_last;
    logic              w_sample;
    logic              w_drive;
    logic [IW-1:0]     w_seq;
    logic [IW-1:0]     w_idx;
    logic              w_first;

`ifdef SPI_LSB_FIRST_EN
    assign w_lsb_in = i_lsb_first;
`else
    assign w_lsb_in = 1'b0;
`endif

    // Edge k: even = leading, odd = trailing; sampling edge parity equals cpha.
    assign w_last   = (r_edge == EW'(2 * DATA_W - 1));
    assign w_sample = (r_edge[0] == r_cpha);
    assign w_drive  = r_cpha ? ~r_edge[0] : (r_edge[0] & ~w_last);
    assign w_seq    = IW'(r_edge >> 1) + IW'(!r_cpha);
    assign w_idx    = r_lsb ? w_seq : (IW'(DATA_W - 1) - w_seq);
    assign w_first  = r_lsb ? r_tx[0] : r_tx[DATA_W-1];

    always_comb begin
        w_state_nxt   = r_state;
        w_edge_nxt    = r_edge;
        w_cpol_nxt    = r_cpol;
        w_cpha_nxt    = r_cpha;
        w_lsb_nxt     = r_lsb;
        w_tx_nxt      = r_tx;
        w_rx_sh_nxt   = r_rx_sh;
        w_sclk_nxt    = r_sclk;
        w_mosi_nxt    = r_mosi;
        w_cs_n_nxt    = r_cs_n;
        w_busy_nxt    = 1'b1;
        w_done_nxt    = 1'b0;
        w_rx_data_nxt = r_rx_data;

        case (r_state)
            IDLE: begin
                w_busy_nxt = 1'b0;
                w_cs_n_nxt = 1'b1;
                w_sclk_nxt = i_cpol;
                if (i_start) begin
                    w_cpol_nxt  = i_cpol;
                    w_cpha_nxt  = i_cpha;
                    w_lsb_nxt   = w_lsb_in;
                    w_tx_nxt    = i_tx_data;
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_cs_n_nxt  = 1'b0;
                w_mosi_nxt  = w_first;
                w_sclk_nxt  = r_cpol;
                w_edge_nxt  = '0;
                w_state_nxt = TRANSFER;
            end
            TRANSFER: begin
                w_sclk_nxt = ~r_sclk;
                w_edge_nxt = r_edge + EW'(1);
                if (w_sample) begin
                    w_rx_sh_nxt = r_lsb ? {i_miso, r_rx_sh[DATA_W-1:1]}
                                        : {r_rx_sh[DATA_W-2:0], i_miso};
                end
                if (w_drive) begin
                    w_mosi_nxt = r_tx[w_idx];
                end
                if (w_last) begin
                    w_edge_nxt  = '0;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                w_cs_n_nxt    = 1'b1;
                w_done_nxt    = 1'b1;
                w_rx_data_nxt = r_rx_sh;
                w_state_nxt   = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge prescale_clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_edge    <= '0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_lsb     <= 1'b0;
            r_tx      <= '0;
            r_rx_sh   <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rx_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_edge    <= w_edge_nxt;
            r_cpol    <= w_cpol_nxt;
            r_cpha    <= w_cpha_nxt;
            r_lsb     <= w_lsb_nxt;
            r_tx      <= w_tx_nxt;
            r_rx_sh   <= w_rx_sh_nxt;
            r_sclk    <= w_sclk_nxt;
            r_mosi    <= w_mosi_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_rx_data <= w_rx_data_nxt;
        end
    end

    assign o_sclk    = r_sclk;
    assign o_mosi    = r_mosi;
    assign o_cs_n    = r_cs_n;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_rx_data = r_rx_data;

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Directed self-checking bench for spi_master_sequencer with a receive-word scoreboard.
module tb_spi_master_sequencer;

    logic       clk;
    logic       rst;
    logic       i_start;
    logic       i_cpol;
    logic       i_cpha;
`ifdef SPI_LSB_FIRST_EN
    logic       i_lsb;
`endif
    logic [7:0] i_tx;
    logic       w_miso;
    logic       o_sclk;
    logic       o_mosi;
    logic       o_cs_n;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_rx;

    logic       r_use_slave;
    logic       r_slv_cpol;
    logic [7:0] r_slv_word;
    logic [2:0] r_slv_idx;
    logic       r_slv_bit;

    logic [7:0] sb[$];
    int         n_tests;
    int         n_fail;

    spi_master_sequencer #(.DATA_W(8)) dut (
        .prescale_clk (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_cpol       (i_cpol),
        .i_cpha       (i_cpha),
`ifdef SPI_LSB_FIRST_EN
        .i_lsb_first  (i_lsb),
`endif
        .i_tx_data    (i_tx),
        .i_miso       (w_miso),
        .o_sclk       (o_sclk),
        .o_mosi       (o_mosi),
        .o_cs_n       (o_cs_n),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_rx_data    (o_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave for cpha=1 modes: shifts its word out MSB first on each leading sclk edge.
    always @(o_sclk or o_cs_n) begin
        if (o_cs_n) begin
            r_slv_idx <= 3'd7;
        end else if (o_sclk != r_slv_cpol) begin
            r_slv_bit <= r_slv_word[r_slv_idx];
            r_slv_idx <= r_slv_idx - 3'd1;
        end
    end

    assign w_miso = r_use_slave ? r_slv_bit : o_mosi;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_xfer(input logic cpol, input logic cpha, input logic lsb,
                            input logic [7:0] tx, input logic [7:0] slave,
                            input logic use_slave, input logic scramble);
        logic [7:0] exp_rx;
        logic       exp_bit;
        int         k;
        exp_rx = use_slave ? slave : tx;
        @(negedge clk);
        i_start     = 1'b1;
        i_cpol      = cpol;
        i_cpha      = cpha;
        i_tx        = tx;
`ifdef SPI_LSB_FIRST_EN
        i_lsb       = lsb;
`endif
        r_use_slave = use_slave;
        r_slv_cpol  = cpol;
        r_slv_word  = slave;
        sb.push_back(exp_rx);
        @(negedge clk);
        i_start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 5 && scramble) begin
                i_cpol = ~cpol;
                i_cpha = ~cpha;
                i_tx   = ~tx;
`ifdef SPI_LSB_FIRST_EN
                i_lsb  = ~lsb;
`endif
            end
            if (n == 1) begin
                exp_bit = lsb ? tx[0] : tx[7];
                chk("setup_cs_n", 32'(o_cs_n), 32'd0);
                chk("setup_busy", 32'(o_busy), 32'd1);
                chk("setup_mosi", 32'(o_mosi), 32'(exp_bit));
                chk("setup_sclk", 32'(o_sclk), 32'(cpol));
            end else if (n <= 17) begin
                k = n - 2;
                chk("xfer_sclk", 32'(o_sclk), 32'(cpol ^ ((k % 2) == 0)));
                if ((k % 2) == int'(cpha)) begin
                    exp_bit = lsb ? tx[k/2] : tx[7 - k/2];
                    chk("xfer_mosi", 32'(o_mosi), 32'(exp_bit));
                end
            end else if (n == 18) begin
                chk("hold_cs_n", 32'(o_cs_n), 32'd0);
                chk("hold_sclk", 32'(o_sclk), 32'(cpol));
                chk("hold_done", 32'(o_done), 32'd0);
            end else if (n == 19) begin
                chk("done_pulse", 32'(o_done), 32'd1);
                chk("done_cs_n", 32'(o_cs_n), 32'd1);
                chk("done_sclk", 32'(o_sclk), 32'(cpol));
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    chk("rx_data", 32'(o_rx), 32'(sb.pop_front()));
                end
            end else begin
                chk("idle_done", 32'(o_done), 32'd0);
                chk("idle_busy", 32'(o_busy), 32'd0);
                chk("idle_sclk", 32'(o_sclk), 32'(i_cpol));
            end
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        i_start     = 1'b0;
        i_cpol      = 1'b0;
        i_cpha      = 1'b0;
        i_tx        = 8'h00;
`ifdef SPI_LSB_FIRST_EN
        i_lsb       = 1'b0;
`endif
        r_use_slave = 1'b0;
        r_slv_cpol  = 1'b0;
        r_slv_word  = 8'h00;
        r_slv_bit   = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_sclk", 32'(o_sclk), 32'd0);
        chk("rst_mosi", 32'(o_mosi), 32'd0);
        chk("rst_cs_n", 32'(o_cs_n), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_rx", 32'(o_rx), 32'd0);
        rst = 1'b0;

        // Reset in the middle of a transfer at k=5
        @(negedge clk);
        i_start = 1'b1;
        i_cpol  = 1'b1;
        i_tx    = 8'hA5;
        @(negedge clk);
        i_start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_abort_busy", 32'(o_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_sclk", 32'(o_sclk), 32'd0);
        chk("abort_cs_n", 32'(o_cs_n), 32'd1);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_rx", 32'(o_rx), 32'd0);
        chk("abort_mosi", 32'(o_mosi), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_abort_done", 32'(o_done), 32'd0);
        chk("post_abort_rx", 32'(o_rx), 32'd0);

        // Mode 0 loopback
        run_xfer(1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0);
        // Mode 3 against slave sending C3
        run_xfer(1'b1, 1'b1, 1'b0, 8'h3C, 8'hC3, 1'b1, 1'b0);
        // Mode 1 and mode 2 with inputs disturbed mid-transfer
        run_xfer(1'b0, 1'b1, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b1);
        run_xfer(1'b1, 1'b0, 1'b0, 8'h96, 8'h00, 1'b0, 1'b1);
        run_xfer(1'b0, 1'b1, 1'b0, 8'h81, 8'h00, 1'b0, 1'b0);

        // start held high: one transfer every 20 cycles
        @(negedge clk);
        i_start     = 1'b1;
        i_cpol      = 1'b0;
        i_cpha      = 1'b0;
        i_tx        = 8'hC9;
        r_use_slave = 1'b0;
        for (int n = 0; n <= 80; n++) begin
            @(negedge clk);
            if ((n % 20) == 0 && n < 80) sb.push_back(8'hC9);
            if (n == 60) i_start = 1'b0;
            chk("b2b_done", 32'(o_done), 32'((n % 20) == 19));
            chk("b2b_busy", 32'(o_busy), 32'((n % 20) != 0));
            if ((n % 20) == 19) begin
                if (sb.size() == 0) begin
                    chk("b2b_sb_empty", 32'd1, 32'd0);
                end else begin
                    chk("b2b_rx", 32'(o_rx), 32'(sb.pop_front()));
                end
            end
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);

`ifdef SPI_LSB_FIRST_EN
        run_xfer(1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0);
        run_xfer(1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0);
        run_xfer(1'b1, 1'b1, 1'b1, 8'hB4, 8'h00, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
